// File: rtl/mux2_share_arb_if.sv
// Handshake bundle between the two requesters and the shared 2:1 mux arbiter.
interface mux2_share_arb_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       owner_valid;
  logic       preempt;
  logic [7:0] gcnt0;
  logic [7:0] gcnt1;

  modport master (
    output req,
    input  gnt, sel, owner_valid, preempt, gcnt0, gcnt1
  );

  modport slave (
    input  req,
    output gnt, sel, owner_valid, preempt, gcnt0, gcnt1
  );
endinterface

// File: rtl/mux2_share_arb.sv
// Round-robin arbiter for a shared 2:1 mux with bounded hold and a break-before-make gap.
// Optional grant-entry counters are built when MUX2_SHARE_ARB_STATS_EN is defined.
module mux2_share_arb #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 8
) (
  input logic             clock,
  input logic             reset,
  mux2_share_arb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_SWITCH} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_last, w_last_nxt;
  logic              r_sel, w_sel_nxt;
  logic              r_preempt, w_preempt_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic              r_owner_valid;
  logic              w_enter0, w_enter1;
  logic              w_own, w_mine, w_other;

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_last_nxt    = r_last;
    w_sel_nxt     = r_sel;
    w_preempt_nxt = 1'b0;
    w_enter0      = 1'b0;
    w_enter1      = 1'b0;
    w_own         = (r_state == S_GRANT1);
    w_mine        = bus.req[w_own];
    w_other       = bus.req[~w_own];

    case (r_state)
      S_IDLE: begin
        if (bus.req == 2'b01)      w_enter0 = 1'b1;
        else if (bus.req == 2'b10) w_enter1 = 1'b1;
        else if (bus.req == 2'b11) begin
          w_enter0 = r_last;
          w_enter1 = ~r_last;
        end
      end
      S_GRANT0, S_GRANT1: begin
        // preempt is registered one cycle ahead: it flags the final grant cycle,
        // and a release seen on the same sample edge wins over expiry.
        if (!w_mine)        w_state_nxt = w_other ? S_SWITCH : S_IDLE;
        else if (r_preempt) w_state_nxt = S_SWITCH;
        else begin
          w_hold_nxt    = w_other ? r_hold + HOLD_W'(1) : '0;
          w_preempt_nxt = w_other && (w_hold_nxt == HOLD_LAST);
        end
      end
      S_SWITCH: begin
        if (bus.req[~r_last]) begin
          w_enter0 = r_last;
          w_enter1 = ~r_last;
        end else if (bus.req[r_last]) begin
          w_enter0 = ~r_last;
          w_enter1 = r_last;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter0 || w_enter1) begin
      w_state_nxt   = w_enter1 ? S_GRANT1 : S_GRANT0;
      w_last_nxt    = w_enter1;
      w_sel_nxt     = w_enter1;
      w_hold_nxt    = '0;
      w_preempt_nxt = (&bus.req) && (HOLD_LAST == '0);
    end

    w_gnt_nxt = {w_state_nxt == S_GRANT1, w_state_nxt == S_GRANT0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_last        <= 1'b1;
      r_sel         <= 1'b0;
      r_preempt     <= 1'b0;
      r_gnt         <= 2'b00;
      r_owner_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_last        <= w_last_nxt;
      r_sel         <= w_sel_nxt;
      r_preempt     <= w_preempt_nxt;
      r_gnt         <= w_gnt_nxt;
      r_owner_valid <= |w_gnt_nxt;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.sel         = r_sel;
  assign bus.owner_valid = r_owner_valid;
  assign bus.preempt     = r_preempt;

`ifdef MUX2_SHARE_ARB_STATS_EN
  logic [7:0] r_gcnt0, r_gcnt1;

  // Entry counters saturate at 255 and only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gcnt0 <= 8'd0;
      r_gcnt1 <= 8'd0;
    end else begin
      if (w_enter0 && (r_gcnt0 != 8'hFF)) r_gcnt0 <= r_gcnt0 + 8'd1;
      if (w_enter1 && (r_gcnt1 != 8'hFF)) r_gcnt1 <= r_gcnt1 + 8'd1;
    end
  end

  assign bus.gcnt0 = r_gcnt0;
  assign bus.gcnt1 = r_gcnt1;
`else
  assign bus.gcnt0 = 8'd0;
  assign bus.gcnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_mux2_share_arb.sv
// Bench for mux2_share_arb: ownership-level reference model plus directed literal vectors.
module tb_mux2_share_arb;

  localparam int MAX_HOLD = 4;

  localparam logic [1:0] EG [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                     2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  localparam logic       ES [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic       EP [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;

  mux2_share_arb_if bus();

  mux2_share_arb #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the mux, whether a gap cycle is pending, how long
  // the other side has been kept waiting.
  int         m_owner  = -1;
  bit         m_gap    = 1'b0;
  int         m_last   = 1;
  int         m_streak = 0;
  bit         m_pre    = 1'b0;
  bit         m_sel    = 1'b0;
  int         m_cnt0   = 0;
  int         m_cnt1   = 0;
  bit         m_on     = 1'b0;
  logic [1:0] m_r;
  logic [1:0] m_gnt;

  task automatic m_take(input int k, input logic [1:0] r);
    m_owner  = k;
    m_sel    = k[0];
    m_last   = k;
    m_streak = 0;
    m_pre    = (r == 2'b11) && (MAX_HOLD == 1);
    if (k == 0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
    else        m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
  endtask

  always @(posedge clk) begin
    m_r = bus.req;
    if (rst) begin
      m_owner = -1; m_gap = 1'b0; m_last = 1; m_streak = 0;
      m_pre = 1'b0; m_sel = 1'b0; m_cnt0 = 0; m_cnt1 = 0; m_on = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
      if (m_r[1-m_last])    m_take(1 - m_last, m_r);
      else if (m_r[m_last]) m_take(m_last, m_r);
    end else if (m_owner < 0) begin
      if (m_r == 2'b01)      m_take(0, m_r);
      else if (m_r == 2'b10) m_take(1, m_r);
      else if (m_r == 2'b11) m_take(1 - m_last, m_r);
    end else if (!m_r[m_owner]) begin
      m_gap   = m_r[1-m_owner];
      m_owner = -1;
      m_pre   = 1'b0;
    end else if (m_pre) begin
      m_gap   = 1'b1;
      m_owner = -1;
      m_pre   = 1'b0;
    end else begin
      m_streak = m_r[1-m_owner] ? m_streak + 1 : 0;
      m_pre    = m_r[1-m_owner] && (m_streak == MAX_HOLD - 1);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      m_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      chk("gnt_onehot", {31'd0, bus.gnt == 2'b11}, 32'd0);
      chk("model_gnt", {30'd0, bus.gnt}, {30'd0, m_gnt});
      chk("model_sel", {31'd0, bus.sel}, {31'd0, m_sel});
      chk("model_ov", {31'd0, bus.owner_valid}, {31'd0, m_owner >= 0});
      chk("model_pre", {31'd0, bus.preempt}, {31'd0, m_pre});
`ifdef MUX2_SHARE_ARB_STATS_EN
      chk("model_gcnt0", {24'd0, bus.gcnt0}, m_cnt0);
      chk("model_gcnt1", {24'd0, bus.gcnt1}, m_cnt1);
`else
      chk("model_gcnt0", {24'd0, bus.gcnt0}, 32'd0);
      chk("model_gcnt1", {24'd0, bus.gcnt1}, 32'd0);
`endif
    end
  end

  task automatic apply(input logic [1:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req = 2'b00;
    rst     = 1'b1;
    apply(2'b00, 1'b1);
    apply(2'b00, 1'b1);
    chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("rst_sel", {31'd0, bus.sel}, 32'd0);
    chk("rst_ov", {31'd0, bus.owner_valid}, 32'd0);
    chk("rst_pre", {31'd0, bus.preempt}, 32'd0);
    chk("rst_gcnt0", {24'd0, bus.gcnt0}, 32'd0);

    // Lone requester 0 keeps the mux with no hold limit.
    apply(2'b01, 1'b0);
    chk("solo0_gnt", {30'd0, bus.gnt}, 32'd1);
    chk("solo0_sel", {31'd0, bus.sel}, 32'd0);
    chk("solo0_ov", {31'd0, bus.owner_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      apply(2'b01, 1'b0);
      chk("solo0_hold_gnt", {30'd0, bus.gnt}, 32'd1);
      chk("solo0_hold_pre", {31'd0, bus.preempt}, 32'd0);
    end

    apply(2'b00, 1'b0);
    chk("drop_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("drop_ov", {31'd0, bus.owner_valid}, 32'd0);
    apply(2'b10, 1'b0);
    chk("solo1_gnt", {30'd0, bus.gnt}, 32'd2);
    chk("solo1_sel", {31'd0, bus.sel}, 32'd1);
    apply(2'b00, 1'b0);

    // Both requesting: 4 grant cycles, 1 gap cycle, alternating owners.
    for (int i = 0; i < 11; i++) begin
      apply(2'b11, 1'b0);
      chk("rr_gnt", {30'd0, bus.gnt}, {30'd0, EG[i]});
      chk("rr_sel", {31'd0, bus.sel}, {31'd0, ES[i]});
      chk("rr_pre", {31'd0, bus.preempt}, {31'd0, EP[i]});
    end

    // Owner 1 releases on the edge that would have armed expiry.
    apply(2'b00, 1'b0);
    chk("idle_gnt", {30'd0, bus.gnt}, 32'd0);
    apply(2'b11, 1'b0);
    chk("tie_last0_gnt", {30'd0, bus.gnt}, 32'd2);
    apply(2'b11, 1'b0);
    apply(2'b11, 1'b0);
    chk("rel_pre_before", {31'd0, bus.preempt}, 32'd0);
    apply(2'b01, 1'b0);
    chk("rel_sw_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("rel_sw_pre", {31'd0, bus.preempt}, 32'd0);
    chk("rel_sw_sel", {31'd0, bus.sel}, 32'd1);
    apply(2'b01, 1'b0);
    chk("rel_after_gnt", {30'd0, bus.gnt}, 32'd1);
    chk("rel_after_sel", {31'd0, bus.sel}, 32'd0);

    // Reset while requester 1 owns the mux.
    apply(2'b10, 1'b0);
    apply(2'b10, 1'b0);
    chk("g1_before_rst", {30'd0, bus.gnt}, 32'd2);
    apply(2'b10, 1'b1);
    chk("midrst_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("midrst_sel", {31'd0, bus.sel}, 32'd0);
    chk("midrst_ov", {31'd0, bus.owner_valid}, 32'd0);
    apply(2'b11, 1'b0);
    chk("postrst_tie_gnt", {30'd0, bus.gnt}, 32'd1);

    // Counter saturation: 1 entry above plus 300 single-cycle pulses.
    apply(2'b00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      apply(2'b01, 1'b0);
      apply(2'b00, 1'b0);
`ifdef MUX2_SHARE_ARB_STATS_EN
      if (i == 9) chk("gcnt0_mid", {24'd0, bus.gcnt0}, 32'd11);
`else
      if (i == 9) chk("gcnt0_mid", {24'd0, bus.gcnt0}, 32'd0);
`endif
    end
`ifdef MUX2_SHARE_ARB_STATS_EN
    chk("gcnt0_sat", {24'd0, bus.gcnt0}, 32'd255);
`else
    chk("gcnt0_sat", {24'd0, bus.gcnt0}, 32'd0);
`endif
    chk("gcnt1_end", {24'd0, bus.gcnt1}, 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux2_share_arb.md
Name: mux2_share_arb

Overview:
- Synchronous arbiter that shares one 2:1 mux datapath (x/y/s/m gate-level mux) between two requesters.
- Requester 0 owns the x input; requester 1 owns the y input.
- Drives the mux select line with round-robin fairness, a bounded hold time, and a one-cycle break-before-make turnaround between owners.
- Sits between the requesting logic and the mux instance; `m` is meaningful to the owner only while `owner_valid` is high.

Parameters:
- MAX_HOLD, 4: max consecutive grant cycles for one owner while the other requester waits; legal range 1..255.
- HOLD_W, 8: width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  request bits; req[0] = x source, req[1] = y source; level-sensitive, held while ownership is wanted.
- gnt  out  2  one-hot-or-zero grant, registered.
- sel  out  1  mux select to port s; 0 selects x, 1 selects y.
- owner_valid  out  1  high when a grant is active (gnt != 00).
- preempt  out  1  one-cycle pulse in the last cycle of a grant removed by MAX_HOLD.
- gcnt0  out  8  grant-entry count for requester 0 (optional feature).
- gcnt1  out  8  grant-entry count for requester 1 (optional feature).

Behaviour:
- Reset values (clock edge with reset=1): state=IDLE, gnt=00, sel=0, owner_valid=0, preempt=0, hold_cnt=0, last=1 (so requester 0 wins the first tie), gcnt0=gcnt1=0.
- Reset mid-operation takes the same values on the next edge and overrides all other transitions.
- All outputs are registered. Latency from req sampled to gnt asserted is 1 cycle from IDLE, or 2 cycles when passing through SWITCH.
- States: IDLE, GRANT0, GRANT1, SWITCH.
- IDLE:
  - req=00: stay in IDLE.
  - Single request k: go to GRANTk.
  - req=11: grant the requester != last.
- GRANTk:
  - Outputs: gnt[k]=1, sel=k, owner_valid=1.
  - Entering GRANTk sets last=k and clears hold_cnt.
  - hold_cnt increments each cycle that req[other]=1 and clears when req[other]=0.
  - req[k]=0 sampled: go to SWITCH if req[other]=1, else to IDLE. No preempt pulse.
  - req[k]=1, req[other]=1, and hold_cnt==MAX_HOLD-1: preempt=1 in this cycle, then go to SWITCH.
  - If the other requester is not requesting, there is no hold limit.
- SWITCH (one cycle):
  - Outputs: gnt=00, owner_valid=0; sel keeps its previous value (break-before-make).
  - Next state: GRANT(other of last) if that request is set; else GRANT(last) if req[last]; else IDLE.
- sel changes only on entry to a GRANT state. It never toggles while owner_valid=1.
- Release and hold expiry in the same cycle are treated as a release; preempt stays 0.
- MAX_HOLD=1 with req=11 continuous: alternates 1 grant cycle and 1 SWITCH cycle, ownership toggling every grant.
- Fairness bound: a continuously requesting requester waits at most MAX_HOLD+1 cycles after the other is granted.
- gnt=11 is illegal and must never occur. The bench asserts this every cycle.

Optional Feature:
- Macro: MUX2_SHARE_ARB_STATS_EN.
- Defined:
  - gcnt0/gcnt1 increment by 1 on each entry to GRANT0/GRANT1.
  - Counters saturate at 255 and clear only on reset.
- Undefined:
  - No counter registers are built; gcnt0 and gcnt1 are tied to 8'd0.
  - Ports stay present in both builds.

Test Plan:
- Reset, then req=01 at cycle 0 -> cycle 1: gnt=01, sel=0, owner_valid=1; held 20 cycles -> gnt=01 throughout, preempt never asserted.
- MAX_HOLD=4, req=11 from IDLE -> gnt=01 for 4 cycles with preempt=1 in the 4th, then 1 cycle of gnt=00 with sel=0, then gnt=10 with sel=1 for 4 cycles; the pattern repeats.
- gnt=01 and req drops to 00 -> next cycle gnt=00, state IDLE; then req=10 -> one cycle later gnt=10, sel=1.
- gnt=10 and req goes 11->01 in the same cycle hold_cnt==MAX_HOLD-1 -> SWITCH with preempt=0, then gnt=01, sel=0.
- reset=1 during GRANT1 -> next edge gnt=00, sel=0, owner_valid=0; then req=11 -> gnt=01 first.
- Stats build: 300 single-cycle req0 pulses separated by idle cycles -> gcnt0=255, gcnt1=0. Non-stats build -> both read 0.
